shift_register_counter: RTL and testbench
=========================================

SHIFT_REGISTER_COUNTER -- requirements
Module: shift_register_counter

Interface
REQ-001 Parameter WIDTH, default 4, is the counter width in bits and SHALL be legal for any value >= 2.
REQ-002 Parameter MODE, default 0, SHALL select the sequence: 0 = ring (one-hot), 1 = Johnson (twisted ring).
REQ-003 Parameter DIR, default 0, SHALL select the shift direction: 0 = toward MSB (left), 1 = toward LSB (right).
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port n_rst, input, 1 bit, SHALL be the reset: asynchronous and active-low.
REQ-006 Port count, output, WIDTH bits, SHALL be the registered counter state, driven directly from flops with no combinational path from inputs.

Function
REQ-007 The counter SHALL advance exactly one step on every rising clk edge while n_rst is high; there is no enable, so it is free-running.
REQ-008 MODE=0, DIR=0: next = {count[WIDTH-2:0], count[WIDTH-1]}, a rotate-left.
- Default sequence: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
REQ-009 MODE=0, DIR=1: next = {count[0], count[WIDTH-1:1]}, a rotate-right.
- Default sequence: 0001 -> 1000 -> 0100 -> 0010 -> 0001.
REQ-010 MODE=1, DIR=0: next = {count[WIDTH-2:0], ~count[WIDTH-1]}.
- Default sequence: 0000 -> 0001 -> 0011 -> 0111 -> 1111 -> 1110 -> 1100 -> 1000 -> 0000.
REQ-011 MODE=1, DIR=1: next = {~count[0], count[WIDTH-1:1]}.
- Default sequence: 0000 -> 1000 -> 1100 -> 1110 -> 1111 -> 0111 -> 0011 -> 0001 -> 0000.
REQ-012 Sequence period SHALL be WIDTH cycles in ring mode and 2*WIDTH cycles in Johnson mode, with wrap-around back to the reset value.
REQ-013 Self-correction, ring mode: if count is not exactly one-hot (zero bits set, or more than one bit set), the next state SHALL be the reset value.
REQ-014 Self-correction, Johnson mode: if count is not a legal Johnson code, the next state SHALL be the reset value.
- A legal Johnson code is a single contiguous run of ones anchored at either the MSB or the LSB, or all-zeros, or all-ones.
REQ-015 Any illegal state SHALL return to the legal sequence within 1 clock cycle.
REQ-016 count SHALL change only on a rising clk edge or on n_rst assertion; it SHALL be glitch-free between edges.

Reset
REQ-017 While n_rst is low, count SHALL be forced immediately, without waiting for a clock edge, to the reset value:
- Ring mode, both DIR values: LSB = 1, all other bits 0 (0001 for the default width).
- Johnson mode: all zeros.
REQ-018 The first rising clk edge with n_rst high SHALL produce the second sequence value.
- Default configuration: count = 0010 after that edge.
REQ-019 Asserting n_rst mid-sequence SHALL abort the sequence and load the reset value asynchronously.
- Counting SHALL resume from step 0 after release.
REQ-020 Reset release SHALL be synchronized by the user; the block itself adds no reset synchronizer.

Verification
REQ-021 Default configuration; hold n_rst low for 1 cycle, then release and run 4 cycles -> count = 0001 during reset, then 0010, 0100, 1000, 0001.
REQ-022 Assert n_rst between clock edges while count = 0100 -> count = 0001 immediately, before the next edge; after release, 0010 follows at the first edge.
REQ-023 MODE=1, DIR=0, WIDTH=4; release reset and run 9 cycles -> count = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
REQ-024 MODE=0; force count to 0110 or to 0000 -> next edge gives count = 0001, then the normal sequence.
REQ-025 MODE=1; force count to 0101 -> next edge gives count = 0000.
REQ-026 MODE=0, DIR=1, WIDTH=8; release reset and run 8 cycles -> count = 0x80, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02, 0x01.

Source files
------------

// File: rtl/shift_register_counter.sv
// Free-running ring / Johnson counter with single-step self-correction.
// Any state outside the selected code space is replaced by the reset value at the next edge.
module shift_register_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MODE  = 0,
   parameter int unsigned DIR   = 0
) (
   input  logic             clk,
   input  logic             n_rst,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] RST_VAL = (MODE == 0) ? WIDTH'(1) : '0;

   logic [WIDTH-1:0] inv_c;
   logic [WIDTH-1:0] shift_c;
   logic             fb_c;
   logic             legal_c;
   logic [WIDTH-1:0] count_nxt;

   // Shift step and legality check of the current state
   always_comb begin
      inv_c   = ~count;
      fb_c    = 1'b0;
      shift_c = count;
      legal_c = 1'b0;

      if (DIR == 0) begin
         fb_c    = (MODE == 0) ? count[WIDTH-1] : ~count[WIDTH-1];
         shift_c = {count[WIDTH-2:0], fb_c};
      end else begin
         fb_c    = (MODE == 0) ? count[0] : ~count[0];
         shift_c = {fb_c, count[WIDTH-1:1]};
      end

      // Ring: exactly one bit set. Johnson: ones anchored at LSB, or zeros anchored at LSB.
      if (MODE == 0) begin
         legal_c = (count != '0) && ((count & (count - WIDTH'(1))) == '0);
      end else begin
         legal_c = ((count & (count + WIDTH'(1))) == '0) ||
                   ((inv_c & (inv_c + WIDTH'(1))) == '0);
      end
   end

   assign count_nxt = legal_c ? shift_c : RST_VAL;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) count <= RST_VAL;
      else        count <= count_nxt;
   end

endmodule

// File: tb/tb_shift_register_counter.sv
// Bench for shift_register_counter: four configurations checked against tabulated
// sequences through an expected-value queue, plus async reset and illegal-state recovery.
module tb_shift_register_counter;

   logic       clk;
   logic       n_rst;
   logic [3:0] c_r4;
   logic [3:0] c_j4;
   logic [7:0] c_r8;
   logic [3:0] c_j4r;
   logic [3:0] force_v;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int         id;
      logic [7:0] val;
      string      tag;
   } exp_t;

   exp_t exp_q[$];

   logic [7:0] ring4_l [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
   logic [7:0] john4_l [8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E, 8'h0C, 8'h08};
   logic [7:0] ring8_r [8] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
   logic [7:0] john4_r [8] = '{8'h00, 8'h08, 8'h0C, 8'h0E, 8'h0F, 8'h07, 8'h03, 8'h01};

   shift_register_counter #(.WIDTH(4), .MODE(0), .DIR(0)) u_r4  (.clk(clk), .n_rst(n_rst), .count(c_r4));
   shift_register_counter #(.WIDTH(4), .MODE(1), .DIR(0)) u_j4  (.clk(clk), .n_rst(n_rst), .count(c_j4));
   shift_register_counter #(.WIDTH(8), .MODE(0), .DIR(1)) u_r8  (.clk(clk), .n_rst(n_rst), .count(c_r8));
   shift_register_counter #(.WIDTH(4), .MODE(1), .DIR(1)) u_j4r (.clk(clk), .n_rst(n_rst), .count(c_j4r));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [7:0] cnt(input int id);
      case (id)
         0:       cnt = {4'h0, c_r4};
         1:       cnt = {4'h0, c_j4};
         2:       cnt = c_r8;
         default: cnt = {4'h0, c_j4r};
      endcase
   endfunction

   // Expected successor from the sequence tables; anything not in the table goes to reset
   function automatic logic [7:0] model_next(input int id, input logic [7:0] v);
      logic [7:0] r;
      r = (id == 0) ? 8'h01 : 8'h00;
      if (id == 0) begin
         for (int i = 0; i < 4; i++) if (ring4_l[i] == v) r = ring4_l[(i + 1) % 4];
      end else begin
         for (int i = 0; i < 8; i++) if (john4_l[i] == v) r = john4_l[(i + 1) % 8];
      end
      return r;
   endfunction

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input int id, input logic [7:0] val, input string tag);
      exp_t e;
      e.id  = id;
      e.val = val;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // One clock edge, then compare every queued expectation
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard: got empty queue expected entries");
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val(e.tag, cnt(e.id), e.val);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      check_val("rst_r4",  cnt(0), 8'h01);
      check_val("rst_j4",  cnt(1), 8'h00);
      check_val("rst_r8",  cnt(2), 8'h01);
      check_val("rst_j4r", cnt(3), 8'h00);
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   // Inject an arbitrary state through the next-state net, then check recovery
   task automatic inject(input int id, input logic [3:0] v);
      logic [7:0] e1;
      @(posedge clk);
      #1;
      force_v = v;
      if (id == 0) force u_r4.count_nxt = force_v;
      else         force u_j4.count_nxt = force_v;
      @(posedge clk);
      #1;
      if (id == 0) release u_r4.count_nxt;
      else         release u_j4.count_nxt;
      check_val("forced", cnt(id), {4'h0, v});
      e1 = model_next(id, {4'h0, v});
      push(id, e1, "recover");
      step();
      push(id, model_next(id, e1), "resume");
      step();
   endtask

   initial begin
      n_rst   = 1'b1;
      force_v = 4'h0;

      // Free-running sequences of all four configurations, with wrap-around
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         push(0, ring4_l[k % 4], "seq_r4");
         push(1, john4_l[k % 8], "seq_j4");
         push(2, ring8_r[k % 8], "seq_r8");
         push(3, john4_r[k % 8], "seq_j4r");
         step();
      end

      // Asynchronous reset mid-sequence while the ring counter shows 0100
      do_reset();
      push(0, 8'h02, "pre_r4");
      step();
      push(0, 8'h04, "pre_r4");
      step();
      #3;
      n_rst = 1'b0;
      #1;
      check_val("async_r4", cnt(0), 8'h01);
      check_val("async_j4", cnt(1), 8'h00);
      @(negedge clk);
      n_rst = 1'b1;
      push(0, 8'h02, "post_r4");
      push(1, 8'h01, "post_j4");
      step();

      // Every 4-bit state, legal or not, in ring and Johnson mode
      for (int v = 0; v < 16; v++) inject(0, 4'(v));
      for (int v = 0; v < 16; v++) inject(1, 4'(v));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
